panel_input: RTL and testbench
==============================

PANEL_INPUT -- requirements
Module: panel_input

Interface
REQ-001 Parameter DB_CYCLES, default 500000, meaning stable-input cycles needed to accept a button or switch change (5 ms at 100 MHz), legal range 2..2^20.
REQ-002 Parameter AUTO_DIV, default 50000000, meaning clk cycles between autorun step pulses, legal range 2..2^27.
REQ-003 clk  input  1  board clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 button  input  1  raw, asynchronous, bouncing push-button; high = pressed.
REQ-006 sw  input  3  raw, asynchronous slide switches selecting the display page.
REQ-007 run  input  1  raw autorun-mode switch; used only when AUTORUN_EN is defined.
REQ-008 step  output  1  single-cycle CPU step pulse, registered.
REQ-009 btn_level  output  1  debounced button level, registered.
REQ-010 sw_sync  output  3  debounced switch value, registered.
REQ-011 sw_changed  output  1  single-cycle pulse when sw_sync takes a new value, registered.

Function
REQ-012 button, each sw bit and run SHALL each pass through a two-flop synchronizer before any other logic.
REQ-013 Button FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-014 In IDLE, a synchronized high SHALL move the FSM to PRESS_WAIT with the debounce counter cleared.
REQ-015 In PRESS_WAIT, the counter SHALL increment while the input is high; any low sample SHALL return the FSM to IDLE; reaching DB_CYCLES-1 SHALL move it to HELD.
REQ-016 On the PRESS_WAIT->HELD transition, step SHALL be high for exactly the following cycle and btn_level SHALL go high.
REQ-017 In HELD, a low sample SHALL move the FSM to RELEASE_WAIT; a held button SHALL produce no further step pulses regardless of duration.
REQ-018 RELEASE_WAIT SHALL mirror PRESS_WAIT with polarity inverted: any high sample returns to HELD; DB_CYCLES-1 consecutive lows go to IDLE and clear btn_level.
REQ-019 The debounce counter SHALL be 20 bits wide, SHALL never wrap, and SHALL clear on every state change.
REQ-020 Switch debounce: a candidate register SHALL reload on any synchronized-sw change, clearing a separate 20-bit counter; after DB_CYCLES-1 stable cycles with candidate != sw_sync, sw_sync SHALL load the candidate and sw_changed SHALL pulse for one cycle.
REQ-021 If sw changes again before the counter completes, the counter SHALL restart and sw_sync SHALL keep its old value.
REQ-022 step and sw_changed events in the same cycle SHALL both be reported; neither SHALL suppress the other.
REQ-023 Latency: button rising edge to step SHALL be DB_CYCLES+3 clk cycles (2 sync, DB_CYCLES-1 count, 1 state, 1 output register), with jitter of ±1 cycle from asynchronous sampling.

Reset
REQ-024 While Reset is low at a rising clk edge: FSM SHALL go to IDLE; all counters, synchronizers, step, btn_level and sw_changed SHALL be 0; sw_sync and candidate SHALL be 3'b000.
REQ-025 Reset asserted mid-debounce SHALL discard the pending event; no step SHALL appear on the cycle after Reset releases, even if button is still high; the press SHALL then be re-qualified from IDLE.

Configuration
REQ-026 Macro PANEL_AUTORUN_EN: when defined, a 27-bit divider SHALL run while synchronized run=1 and emit a step pulse every AUTO_DIV cycles; manual step pulses SHALL be ignored during autorun; the divider SHALL clear when run=0 or under reset.
REQ-027 When PANEL_AUTORUN_EN is undefined, the run input SHALL be unused, no divider logic SHALL exist, and step SHALL come only from the button FSM.

Verification (DB_CYCLES=4, AUTO_DIV=8)
REQ-028 Clean press: button high for 20 cycles -> exactly one step pulse, 7±1 cycles after the edge; btn_level high until 6±1 cycles after release.
REQ-029 Bounce: button toggles high/low every 2 cycles for 16 cycles, then stays high -> no step during the toggling; one step after stable high.
REQ-030 Switch: sw 000->101 held steady -> sw_sync=101 with one sw_changed pulse; sw 101->011->101 within 3 cycles -> no sw_changed pulse.
REQ-031 Reset mid-press: Reset low for 1 cycle during PRESS_WAIT with button held -> no step until a full re-qualification of 4 cycles after Reset releases.
REQ-032 With PANEL_AUTORUN_EN, run=1 for 40 cycles -> step pulses spaced exactly 8 cycles apart; button presses meanwhile produce no additional pulses.

Source files
------------

// File: rtl/panel_input.sv
// Front-panel input conditioner: synchronizes and debounces the step button and page switches.
// Optional autorun stepping is compiled in when PANEL_AUTORUN_EN is defined.
module panel_input #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned AUTO_DIV  = 50000000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       button,
    input  logic [2:0] sw,
    input  logic       run,
    output logic       step,
    output logic       btn_level,
    output logic [2:0] sw_sync,
    output logic       sw_changed
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned SW_W  = 3;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btn_state_e;

    logic             btn_s1_q, btn_s2_q;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_step_c;

    logic [SW_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [SW_W-1:0]  sw_sync_q, sw_sync_d;
    logic             sw_changed_q, sw_changed_d;

    logic             step_q, step_d;

    // Two-flop synchronizers on the raw asynchronous inputs
    always_ff @(posedge clk) begin
        if (!Reset) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Button FSM: counter clears on every state change, so it can never wrap
    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        btn_level_d  = btn_level_q;
        press_step_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s2_q) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s2_q) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d      = HELD;
                    db_cnt_d     = '0;
                    btn_level_d  = 1'b1;
                    press_step_c = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s2_q) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s2_q) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    db_cnt_d    = '0;
                    btn_level_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    // Switch debounce: any change reloads the candidate and restarts the count
    always_comb begin
        cand_d       = cand_q;
        sw_cnt_d     = sw_cnt_q;
        sw_sync_d    = sw_sync_q;
        sw_changed_d = 1'b0;
        if (sw_s2_q != cand_q) begin
            cand_d   = sw_s2_q;
            sw_cnt_d = '0;
        end else if (sw_cnt_q == DB_LAST) begin
            if (cand_q != sw_sync_q) begin
                sw_sync_d    = cand_q;
                sw_changed_d = 1'b1;
            end
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_W'(1);
        end
    end

`ifdef PANEL_AUTORUN_EN
    localparam int unsigned DIV_W = 27;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(AUTO_DIV - 1);

    logic             run_s1_q, run_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             auto_step_c;

    always_ff @(posedge clk) begin
        if (!Reset) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            div_q    <= '0;
        end else begin
            run_s1_q <= run;
            run_s2_q <= run_s1_q;
            div_q    <= div_d;
        end
    end

    // Autorun owns the step output while run is high; manual presses are masked
    always_comb begin
        div_d       = '0;
        auto_step_c = 1'b0;
        if (run_s2_q) begin
            if (div_q == DIV_LAST) begin
                auto_step_c = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
        step_d = run_s2_q ? auto_step_c : press_step_c;
    end
`else
    logic unused_run;
    assign unused_run = run;
    assign step_d     = press_step_c;
`endif

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            btn_level_q  <= 1'b0;
            cand_q       <= '0;
            sw_cnt_q     <= '0;
            sw_sync_q    <= '0;
            sw_changed_q <= 1'b0;
            step_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            btn_level_q  <= btn_level_d;
            cand_q       <= cand_d;
            sw_cnt_q     <= sw_cnt_d;
            sw_sync_q    <= sw_sync_d;
            sw_changed_q <= sw_changed_d;
            step_q       <= step_d;
        end
    end

    assign step       = step_q;
    assign btn_level  = btn_level_q;
    assign sw_sync    = sw_sync_q;
    assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_panel_input.sv
// Scoreboard bench for panel_input with DB_CYCLES=4, AUTO_DIV=8; autorun section under PANEL_AUTORUN_EN.
module tb_panel_input;

    logic       clk = 1'b0;
    logic       Reset;
    logic       button;
    logic [2:0] sw;
    logic       run;
    logic       step;
    logic       btn_level;
    logic [2:0] sw_sync;
    logic       sw_changed;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int last_step = 0;

    typedef struct {
        int         lo;
        int         hi;
        int         gap;
        logic [2:0] val;
    } exp_t;

    exp_t step_exp[$];
    exp_t swc_exp[$];

    panel_input #(.DB_CYCLES(4), .AUTO_DIV(8)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .button     (button),
        .sw         (sw),
        .run        (run),
        .step       (step),
        .btn_level  (btn_level),
        .sw_sync    (sw_sync),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        check(name, act == req, $sformatf("got %0d, required %0d", act, req));
    endtask

    task automatic push_step(input int lo, input int hi, input int gap);
        exp_t e;
        e.lo = lo; e.hi = hi; e.gap = gap; e.val = 3'b000;
        step_exp.push_back(e);
    endtask

    task automatic push_swc(input int lo, input int hi, input logic [2:0] val);
        exp_t e;
        e.lo = lo; e.hi = hi; e.gap = 0; e.val = val;
        swc_exp.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (step === 1'b1) begin
            if (step_exp.size() == 0) begin
                check("step_unexpected", 1'b0, $sformatf("step pulse at cycle %0d, required none", cyc));
            end else begin
                e = step_exp.pop_front();
                check("step_time", cyc >= e.lo && cyc <= e.hi,
                      $sformatf("got cycle %0d, required %0d..%0d", cyc, e.lo, e.hi));
                if (e.gap != 0)
                    check_val("step_gap", cyc - last_step, e.gap);
            end
            last_step = cyc;
        end
        if (sw_changed === 1'b1) begin
            if (swc_exp.size() == 0) begin
                check("swc_unexpected", 1'b0, $sformatf("sw_changed at cycle %0d, required none", cyc));
            end else begin
                e = swc_exp.pop_front();
                check("swc_time", cyc >= e.lo && cyc <= e.hi,
                      $sformatf("got cycle %0d, required %0d..%0d", cyc, e.lo, e.hi));
                check_val("swc_value", int'(sw_sync), int'(e.val));
            end
        end
    end

    initial begin
        int n;
        Reset  = 1'b0;
        button = 1'b0;
        sw     = 3'b000;
        run    = 1'b0;
        tick(3);
        check_val("rst_step", int'(step), 0);
        check_val("rst_btn_level", int'(btn_level), 0);
        check_val("rst_sw_sync", int'(sw_sync), 0);
        check_val("rst_sw_changed", int'(sw_changed), 0);
        Reset = 1'b1;
        tick(3);

        // Clean press held 20 cycles
        n = cyc;
        button = 1'b1;
        push_step(n + 6, n + 8, 0);
        tick(20);
        check_val("press_btn_level", int'(btn_level), 1);
        button = 1'b0;
        tick(4);
        check_val("release_early_level", int'(btn_level), 1);
        tick(4);
        check_val("release_level", int'(btn_level), 0);
        tick(4);

        // Bounce: toggle every 2 cycles for 16 cycles, then stable high
        for (int i = 0; i < 8; i++) begin
            button = ~i[0];
            tick(2);
        end
        check_val("bounce_level", int'(btn_level), 0);
        n = cyc;
        button = 1'b1;
        push_step(n + 6, n + 8, 0);
        tick(12);
        check_val("bounce_settled_level", int'(btn_level), 1);
        button = 1'b0;
        tick(10);

        // Switch change, then a 3-cycle glitch that must be rejected
        n = cyc;
        sw = 3'b101;
        push_swc(n + 6, n + 8, 3'b101);
        tick(12);
        check_val("sw_sync_101", int'(sw_sync), 5);
        sw = 3'b011;
        tick(3);
        sw = 3'b101;
        tick(12);
        check_val("sw_glitch_hold", int'(sw_sync), 5);

        // Button press and switch change landing on the same cycle
        n = cyc;
        sw = 3'b110;
        button = 1'b1;
        push_swc(n + 6, n + 8, 3'b110);
        push_step(n + 6, n + 8, 0);
        tick(12);
        button = 1'b0;
        tick(10);
        check_val("sw_sync_110", int'(sw_sync), 6);

        // Reset pulse during PRESS_WAIT with button held
        button = 1'b1;
        tick(4);
        Reset = 1'b0;
        tick(1);
        Reset = 1'b1;
        n = cyc;
        check_val("midrst_sw_sync", int'(sw_sync), 0);
        check_val("midrst_level", int'(btn_level), 0);
        push_step(n + 6, n + 8, 0);
        push_swc(n + 6, n + 8, 3'b110);
        tick(12);
        check_val("midrst_requal_level", int'(btn_level), 1);
        button = 1'b0;
        tick(10);

`ifdef PANEL_AUTORUN_EN
        // Autorun for 40 cycles with a manual press in the middle
        n = cyc;
        run = 1'b1;
        for (int k = 0; k < 5; k++)
            push_step(n + 9 + 8 * k, n + 11 + 8 * k, (k == 0) ? 0 : 8);
        tick(14);
        button = 1'b1;
        tick(12);
        button = 1'b0;
        tick(14);
        run = 1'b0;
        tick(16);
`endif

        tick(5);
        while (step_exp.size() != 0) begin
            exp_t e;
            e = step_exp.pop_front();
            check("step_missing", 1'b0, $sformatf("no pulse seen, required one in %0d..%0d", e.lo, e.hi));
        end
        while (swc_exp.size() != 0) begin
            exp_t e;
            e = swc_exp.pop_front();
            check("swc_missing", 1'b0, $sformatf("no pulse seen, required one in %0d..%0d", e.lo, e.hi));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
